// File: rtl/dma_apb_master.sv
// Purpose: single-outstanding APB master that turns DMA core requests into SETUP/ACCESS transfers.
// Latency: 3 cycles from accept edge to o_rsp_vld with zero wait states; +1 per PREADY-low cycle, capped at TIMEOUT_CYCLES.
// Backpressure: o_req_rdy only in IDLE; response is a one-cycle pulse with no backpressure.
module dma_apb_master #(
  parameter int APB_SVL        = 4,
  parameter int APB_ADDR_WIDTH = 16,
  parameter int APB_DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_req_vld,
  output logic                          o_req_rdy,
  input  logic [APB_ADDR_WIDTH-1:0]     i_req_addr,
  input  logic                          i_req_write,
  input  logic [APB_DATA_WIDTH-1:0]     i_req_wdata,
  output logic                          o_rsp_vld,
  output logic [APB_DATA_WIDTH-1:0]     o_rsp_rdata,
  output logic                          o_rsp_err,
  output logic [$clog2(APB_SVL)-1:0]    o_psel,
  output logic                          o_psel_vld,
  output logic                          o_penable,
  output logic [APB_ADDR_WIDTH-1:0]     o_paddr,
  output logic                          o_pwrite,
  output logic [APB_DATA_WIDTH-1:0]     o_pwdata,
  input  logic                          i_pready,
  input  logic [APB_DATA_WIDTH-1:0]     i_prdata,
  output logic                          o_busy
);

  localparam int PSW = $clog2(APB_SVL);
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                      r_state;
  logic [CW-1:0]               r_wait_cnt;
  logic [PSW-1:0]              r_psel;
  logic [APB_ADDR_WIDTH-1:0]   r_paddr;
  logic                        r_pwrite;
  logic [APB_DATA_WIDTH-1:0]   r_pwdata;
  logic                        r_rsp_vld;
  logic                        r_rsp_err;
  logic [APB_DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                        w_last_wait;

  // Counter only runs 0..TIMEOUT_CYCLES-1, so reaching the last value ends the transfer before any wrap.
  assign w_last_wait = (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Transfer sequencer: latches the request in IDLE, walks SETUP->ACCESS, and registers the response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_psel      <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_vld   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req_vld) begin
            r_psel   <= i_req_addr[APB_ADDR_WIDTH-1 -: PSW];
            r_paddr  <= i_req_addr;
            r_pwrite <= i_req_write;
            r_pwdata <= i_req_wdata;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_wait_cnt <= '0;
          r_state    <= ACCESS;
        end
        ACCESS: begin
          // A ready slave wins even on the last permitted cycle.
          if (i_pready) begin
            r_rsp_vld   <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_pwrite ? '0 : i_prdata;
            r_state     <= IDLE;
          end else if (w_last_wait) begin
            r_rsp_vld   <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake/qualifier outputs decode straight from state so an async reset drops them immediately.
  assign o_req_rdy   = (r_state == IDLE);
  assign o_psel_vld  = (r_state != IDLE);
  assign o_penable   = (r_state == ACCESS);
  assign o_busy      = (r_state != IDLE);
  assign o_psel      = r_psel;
  assign o_paddr     = r_paddr;
  assign o_pwrite    = r_pwrite;
  assign o_pwdata    = r_pwdata;
  assign o_rsp_vld   = r_rsp_vld;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dma_apb_master.sv
// Purpose: self-checking bench for dma_apb_master with a scripted APB slave and response scoreboard.
// Latency: responses expected 3 + wait-state cycles after acceptance, 18 on timeout.
// Backpressure: requests only driven when o_req_rdy is seen high.
module tb_dma_apb_master;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SVL = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_req_vld;
  logic          o_req_rdy;
  logic [AW-1:0] i_req_addr;
  logic          i_req_write;
  logic [DW-1:0] i_req_wdata;
  logic          o_rsp_vld;
  logic [DW-1:0] o_rsp_rdata;
  logic          o_rsp_err;
  logic [1:0]    o_psel;
  logic          o_psel_vld;
  logic          o_penable;
  logic [AW-1:0] o_paddr;
  logic          o_pwrite;
  logic [DW-1:0] o_pwdata;
  logic          i_pready;
  logic [DW-1:0] i_prdata;
  logic          o_busy;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   slv_wait = 0;
  logic [DW-1:0] slv_data = '0;
  int   acc_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dma_apb_master #(
    .APB_SVL(SVL), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy),
    .i_req_addr(i_req_addr), .i_req_write(i_req_write), .i_req_wdata(i_req_wdata),
    .o_rsp_vld(o_rsp_vld), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_psel(o_psel), .o_psel_vld(o_psel_vld), .o_penable(o_penable),
    .o_paddr(o_paddr), .o_pwrite(o_pwrite), .o_pwdata(o_pwdata),
    .i_pready(i_pready), .i_prdata(i_prdata), .o_busy(o_busy)
  );

  // Slave: ready on ACCESS cycle number slv_wait (0-based); outside ACCESS drives junk with PREADY high.
  initial begin
    i_pready = 1'b1;
    i_prdata = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (o_penable === 1'b1) begin
        i_pready = (acc_cnt == slv_wait);
        i_prdata = slv_data;
        acc_cnt++;
      end else begin
        acc_cnt  = 0;
        i_pready = 1'b1;
        i_prdata = 16'hDEAD;
      end
    end
  end

  // Scoreboard monitor: every response pops the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (i_rst_n === 1'b1 && o_rsp_vld === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected_rsp: got rsp_vld=1 rdata=%h err=%b, required no response", o_rsp_rdata, o_rsp_err);
        end else begin
          mon_e = sb.pop_front();
          if ({o_rsp_rdata, o_rsp_err} !== {mon_e.rdata, mon_e.err}) begin
            n_bad++;
            $display("FAIL sb_rsp: got rdata=%h err=%b, required rdata=%h err=%b",
                     o_rsp_rdata, o_rsp_err, mon_e.rdata, mon_e.err);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd,
                       input int wt, input logic [DW-1:0] rd);
    exp_t e;
    int g;
    g = 0;
    @(negedge clk);
    while (o_req_rdy !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (g >= 50) begin
      n_bad++;
      $display("FAIL issue_rdy: got o_req_rdy=%b after 50 cycles, required 1", o_req_rdy);
    end
    i_req_vld   = 1'b1;
    i_req_addr  = a;
    i_req_write = wr;
    i_req_wdata = wd;
    slv_wait    = wt;
    slv_data    = rd;
    e.err   = (wt >= TO);
    e.rdata = (wr || e.err) ? '0 : rd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    i_req_vld   = 1'b0;
    i_req_addr  = AW'($urandom);
    i_req_write = 1'($urandom);
    i_req_wdata = DW'($urandom);
  endtask

  task automatic wait_rsp(output int lat, output int pen, output logic stable, output logic setup_ok,
                          output logic [1:0] ps, output logic [AW-1:0] pa, output logic pw,
                          output logic [DW-1:0] pd);
    lat = 0;
    pen = 0;
    stable = 1'b1;
    @(negedge clk);
    lat = 1;
    setup_ok = o_psel_vld && !o_penable && o_busy && !o_req_rdy;
    ps = o_psel;
    pa = o_paddr;
    pw = o_pwrite;
    pd = o_pwdata;
    while (o_rsp_vld !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (o_penable === 1'b1) pen++;
      if ({o_psel, o_paddr, o_pwrite, o_pwdata} !== {ps, pa, pw, pd}) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b1;
    i_req_vld = 1'b0;
    i_req_addr = 16'hFFFF;
    i_req_write = 1'b1;
    i_req_wdata = 16'hFFFF;
    #1 i_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({o_psel_vld, o_penable, o_rsp_vld, o_rsp_err, o_busy, o_pwrite} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b, required 000000", {o_psel_vld, o_penable, o_rsp_vld, o_rsp_err, o_busy, o_pwrite});
    end
    n_cmp++;
    if ({o_psel, o_paddr, o_pwdata, o_rsp_rdata} !== 50'b0) begin
      n_bad++;
      $display("FAIL reset_data: got psel=%h paddr=%h pwdata=%h rdata=%h, required all 0", o_psel, o_paddr, o_pwdata, o_rsp_rdata);
    end
    i_rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_req_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_rdy: got %b, required 1", o_req_rdy);
    end
  endtask

  task automatic test_read_zero_wait();
    int lat, pen;
    logic st, su, pw;
    logic [1:0] ps;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    issue(16'h8004, 1'b0, 16'h5555, 0, 16'hBEEF);
    wait_rsp(lat, pen, st, su, ps, pa, pw, pd);
    n_cmp++;
    if (lat !== 3 || pen !== 1) begin
      n_bad++;
      $display("FAIL rd0_latency: got lat=%0d pen=%0d, required lat=3 pen=1", lat, pen);
    end
    n_cmp++;
    if ({su, st, ps, pa, pw} !== {1'b1, 1'b1, 2'd2, 16'h8004, 1'b0}) begin
      n_bad++;
      $display("FAIL rd0_apb: got setup=%b stable=%b psel=%0d paddr=%h pwrite=%b, required 1 1 2 8004 0", su, st, ps, pa, pw);
    end
    n_cmp++;
    if ({o_rsp_rdata, o_rsp_err} !== {16'hBEEF, 1'b0}) begin
      n_bad++;
      $display("FAIL rd0_rsp: got rdata=%h err=%b, required beef 0", o_rsp_rdata, o_rsp_err);
    end
    n_cmp++;
    if ({o_psel_vld, o_penable, o_busy, o_req_rdy} !== 4'b0001) begin
      n_bad++;
      $display("FAIL rd0_idle: got %b, required 0001", {o_psel_vld, o_penable, o_busy, o_req_rdy});
    end
  endtask

  task automatic test_write_wait();
    int lat, pen;
    logic st, su, pw;
    logic [1:0] ps;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    issue(16'hC010, 1'b1, 16'h1234, 3, 16'hAAAA);
    wait_rsp(lat, pen, st, su, ps, pa, pw, pd);
    n_cmp++;
    if (lat !== 6 || pen !== 4) begin
      n_bad++;
      $display("FAIL wr3_latency: got lat=%0d pen=%0d, required lat=6 pen=4", lat, pen);
    end
    n_cmp++;
    if ({su, st, ps, pa, pw, pd} !== {1'b1, 1'b1, 2'd3, 16'hC010, 1'b1, 16'h1234}) begin
      n_bad++;
      $display("FAIL wr3_apb: got setup=%b stable=%b psel=%0d paddr=%h pwrite=%b pwdata=%h, required 1 1 3 c010 1 1234", su, st, ps, pa, pw, pd);
    end
    n_cmp++;
    if ({o_rsp_rdata, o_rsp_err} !== {16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL wr3_rsp: got rdata=%h err=%b, required 0000 0", o_rsp_rdata, o_rsp_err);
    end
  endtask

  task automatic test_timeout();
    int lat, pen;
    logic st, su, pw;
    logic [1:0] ps;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    issue(16'h4002, 1'b0, 16'h0000, 1000, 16'h7777);
    wait_rsp(lat, pen, st, su, ps, pa, pw, pd);
    n_cmp++;
    if (lat !== 18 || pen !== 16) begin
      n_bad++;
      $display("FAIL to_latency: got lat=%0d pen=%0d, required lat=18 pen=16", lat, pen);
    end
    n_cmp++;
    if ({o_rsp_rdata, o_rsp_err} !== {16'h0000, 1'b1}) begin
      n_bad++;
      $display("FAIL to_rsp: got rdata=%h err=%b, required 0000 1", o_rsp_rdata, o_rsp_err);
    end
    @(negedge clk);
    n_cmp++;
    if ({o_rsp_vld, o_rsp_err} !== 2'b01) begin
      n_bad++;
      $display("FAIL to_hold: got vld=%b err=%b, required 0 1", o_rsp_vld, o_rsp_err);
    end
    issue(16'h0006, 1'b0, 16'h0000, 1, 16'h1357);
    wait_rsp(lat, pen, st, su, ps, pa, pw, pd);
    n_cmp++;
    if (lat !== 4 || {o_rsp_rdata, o_rsp_err} !== {16'h1357, 1'b0}) begin
      n_bad++;
      $display("FAIL to_next: got lat=%0d rdata=%h err=%b, required 4 1357 0", lat, o_rsp_rdata, o_rsp_err);
    end
  endtask

  task automatic test_boundary();
    int lat, pen;
    logic st, su, pw;
    logic [1:0] ps;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    issue(16'h4ABC, 1'b0, 16'h0000, TO - 1, 16'hC0DE);
    wait_rsp(lat, pen, st, su, ps, pa, pw, pd);
    n_cmp++;
    if (lat !== 18 || pen !== 16 || ps !== 2'd1) begin
      n_bad++;
      $display("FAIL bnd_latency: got lat=%0d pen=%0d psel=%0d, required 18 16 1", lat, pen, ps);
    end
    n_cmp++;
    if ({o_rsp_rdata, o_rsp_err} !== {16'hC0DE, 1'b0}) begin
      n_bad++;
      $display("FAIL bnd_rsp: got rdata=%h err=%b, required c0de 0", o_rsp_rdata, o_rsp_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    logic          wrs   [3];
    logic [DW-1:0] dats  [3];
    int rel [3];
    int c0, nreq, nrsp;
    exp_t e;
    addrs[0] = 16'h1000; addrs[1] = 16'h5002; addrs[2] = 16'h9004;
    wrs[0] = 1'b0; wrs[1] = 1'b1; wrs[2] = 1'b0;
    dats[0] = 16'h0A0A; dats[1] = 16'h0B0B; dats[2] = 16'h0C0C;
    c0 = 0; nreq = 0; nrsp = 0;
    for (int k = 0; k < 3; k++) rel[k] = -1;
    slv_wait = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_rsp_vld === 1'b1) begin
        if (nrsp < 3) rel[nrsp] = cyc - c0;
        nrsp++;
      end
      if (o_psel_vld === 1'b1 && o_penable === 1'b0 && nreq > 0) begin
        n_cmp++;
        if (o_paddr !== addrs[nreq-1]) begin
          n_bad++;
          $display("FAIL b2b_paddr: got %h, required %h", o_paddr, addrs[nreq-1]);
        end
      end
      if (o_req_rdy === 1'b1) begin
        if (nreq < 3) begin
          if (nreq == 0) c0 = cyc;
          i_req_vld   = 1'b1;
          i_req_addr  = addrs[nreq];
          i_req_write = wrs[nreq];
          i_req_wdata = dats[nreq];
          slv_data    = dats[nreq] ^ 16'hFFFF;
          e.err   = 1'b0;
          e.rdata = wrs[nreq] ? '0 : (dats[nreq] ^ 16'hFFFF);
          sb.push_back(e);
          nreq++;
        end else begin
          i_req_vld = 1'b0;
        end
      end else begin
        i_req_addr  = AW'($urandom);
        i_req_write = 1'($urandom);
        i_req_wdata = DW'($urandom);
      end
    end
    i_req_vld = 1'b0;
    n_cmp++;
    if (nrsp !== 3 || rel[0] !== 3 || rel[1] !== 6 || rel[2] !== 9) begin
      n_bad++;
      $display("FAIL b2b_timing: got n=%0d at T%0d T%0d T%0d, required 3 at T3 T6 T9", nrsp, rel[0], rel[1], rel[2]);
    end
  endtask

  task automatic test_reset_mid();
    int g, lat, pen;
    logic st, su, pw;
    logic [1:0] ps;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    issue(16'h8008, 1'b0, 16'h0000, 1000, 16'h1111);
    g = 0;
    while (o_penable !== 1'b1 && g < 10) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    #2 i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_psel_vld, o_penable, o_busy, o_rsp_vld} !== 4'b0000) begin
      n_bad++;
      $display("FAIL rstmid_async: got %b, required 0000", {o_psel_vld, o_penable, o_busy, o_rsp_vld});
    end
    sb.delete();
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_rsp_vld, o_busy, o_req_rdy, o_paddr} !== {3'b001, 16'h0000}) begin
      n_bad++;
      $display("FAIL rstmid_after: got vld=%b busy=%b rdy=%b paddr=%h, required 0 0 1 0000", o_rsp_vld, o_busy, o_req_rdy, o_paddr);
    end
    issue(16'h0100, 1'b1, 16'hFACE, 2, 16'h0000);
    wait_rsp(lat, pen, st, su, ps, pa, pw, pd);
    n_cmp++;
    if (lat !== 5 || pd !== 16'hFACE || o_rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_recover: got lat=%0d pwdata=%h err=%b, required 5 face 0", lat, pd, o_rsp_err);
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_timeout();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
